dpm_req_scheduler: RTL
======================

// Module: dpm_req_scheduler
// PURPOSE
//  Power-mode sequencer and round-robin arbiter for the DPM unit. Gathers activity
//  requests from N_REQ clients, wakes the unit from SLEEP, and grants the shared
//  datapath to one client at a time. Drops to IDLE (clock gated) and then SLEEP
//  (power gated) after programmable inactivity timeouts. Sits between the clients
//  and the DPM datapath's clock/power enables.
// PARAMETERS
//  N_REQ         4   number of requesting clients (2..8)
//  WAKE_LAT      3   cycles spent in WAKE before ACTIVE (>=1)
//  IDLE_TIMEOUT  8   consecutive inactive ACTIVE cycles before IDLE (>=1)
//  SLEEP_TIMEOUT 16  consecutive request-free IDLE cycles before SLEEP (>=1)
//  CNT_W         8   timeout counter width; must exceed clog2 of the largest timeout
// PORTS
//  clk        in   1      clock
//  rst        in   1      asynchronous, active-high reset
//  req        in   N_REQ  level activity request, one bit per client
//  done       in   N_REQ  one-cycle pulse: client releases its grant
//  grant      out  N_REQ  one-hot (or zero) registered datapath grant
//  pwr_state  out  2      00 ACTIVE, 01 IDLE, 10 SLEEP, 11 WAKE
//  clk_en     out  1      datapath clock enable (1 only in ACTIVE)
//  pwr_en     out  1      datapath power enable (0 only in SLEEP)
//  wake_cnt   out  16     saturating SLEEP->WAKE count (only with DPM_WAKE_CNT_EN)
// BEHAVIOUR
//  Reset (async, immediate at any time, including mid-grant or mid-WAKE):
//   state=SLEEP, grant=0, clk_en=0, pwr_en=0, counters=0, RR pointer=0.
//  All outputs are registered; clk_en/pwr_en decode the state register only.
//  SLEEP: any req bit set at edge t -> WAKE at t+1; wake counter loads WAKE_LAT.
//  WAKE: pwr_en=1, clk_en=0; after WAKE_LAT cycles -> ACTIVE. req is ignored
//   (not lost; it is level) during WAKE. WAKE never aborts back to SLEEP.
//  ACTIVE: clk_en=1, pwr_en=1. Grant issued only when grant==0 and req!=0:
//   winner is the first set req bit at or after the RR pointer (wrap N_REQ-1->0).
//   The grant is visible one cycle after arbitration. It is held until done[i]
//   arrives with grant[i]=1. Then grant=0 next cycle, and the pointer = i+1 mod N_REQ.
//   New arbitration happens the following cycle, so there is one dead cycle between grants.
//   A req drop while granted does not release the grant; only done does.
//   done bits not matching the active grant are ignored.
//  Idle counter: clears on any cycle with req!=0 or grant!=0. Otherwise it increments
//   in ACTIVE. At IDLE_TIMEOUT -> IDLE (grant is 0 by construction).
//  IDLE: clk_en=0, pwr_en=1. Any req -> ACTIVE next cycle, counter cleared.
//   Otherwise the counter increments. At SLEEP_TIMEOUT -> SLEEP.
//  Simultaneous req and timeout expiry on the same edge: req wins, no demotion.
//  Counters never wrap: they saturate at their terminal value.
// CONFIGURATION
//  DPM_WAKE_CNT_EN defined: wake_cnt port exists. It increments on each SLEEP->WAKE
//   transition, saturates at 16'hFFFF, and resets to 0.
//  Undefined: no wake_cnt port and no counter logic; all other behaviour is identical.
// STRUCTURE
//  dpm_pkg: pwr_state_t enum with the encodings above, DPM_STATE_W=2, and
//   localparam helpers for the timeout defaults.
//  Sub-module dpm_rr_arb: combinational round-robin pick (req, ptr -> one-hot,
//   valid, index). The scheduler owns the pointer, grant register, FSM and counters.
// TESTING (defaults)
//  Reset: rst=1 mid-run -> same cycle grant=0, pwr_state=10, clk_en=0, pwr_en=0.
//  Wake: from SLEEP, req=0001 at edge t -> WAKE t+1, ACTIVE t+4, grant=0001 t+5.
//  RR fairness: req=1011 held, done pulsed per grant -> grants 0001,0010,1000,0001
//   with one zero-grant cycle between each.
//  Hold: grant=0100, then req[2] dropped without done -> grant stays 0100 until done[2].
//   done[1] meanwhile is ignored.
//  Timeouts: all req=0 after last done -> IDLE after 8 cycles, SLEEP after a further 16.
//   req=0010 in the IDLE cycle where the count hits 16 -> ACTIVE, no SLEEP.
//  DPM_WAKE_CNT_EN: three SLEEP->WAKE cycles -> wake_cnt=3. Build without the macro
//   elaborates cleanly and passes all of the above.

Source files
------------

// File: rtl/dpm_pkg.sv
// Shared types and defaults for the DPM request scheduler: power-state encoding,
// default parameter values and state-to-enable decode helpers.
package dpm_pkg;

  localparam int DPM_STATE_W = 2;

  typedef enum logic [DPM_STATE_W-1:0] {
    ST_ACTIVE = 2'b00,
    ST_IDLE   = 2'b01,
    ST_SLEEP  = 2'b10,
    ST_WAKE   = 2'b11
  } pwr_state_t;

  localparam int DPM_N_REQ_DEF         = 4;
  localparam int DPM_WAKE_LAT_DEF      = 3;
  localparam int DPM_IDLE_TIMEOUT_DEF  = 8;
  localparam int DPM_SLEEP_TIMEOUT_DEF = 16;
  localparam int DPM_CNT_W_DEF         = 8;
  localparam int DPM_WAKE_CNT_W        = 16;

  // Datapath enables are pure functions of the power state.
  function automatic logic dpm_clk_en(input pwr_state_t s);
    return (s == ST_ACTIVE);
  endfunction

  function automatic logic dpm_pwr_en(input pwr_state_t s);
    return (s != ST_SLEEP);
  endfunction

endpackage

// File: rtl/dpm_rr_arb.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping from N_REQ-1 back to 0. Returns one-hot, valid and index.
module dpm_rr_arb
  import dpm_pkg::*;
#(
  parameter int N_REQ = DPM_N_REQ_DEF,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  // One extra bit so ptr + offset can exceed N_REQ before the wrap.
  logic [IDX_W:0] w_pos;

  always_comb begin
    o_onehot = '0;
    o_valid  = 1'b0;
    o_idx    = '0;
    w_pos    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_pos = {1'b0, i_ptr} + (IDX_W+1)'(i);
      if (w_pos >= (IDX_W+1)'(N_REQ)) begin
        w_pos = w_pos - (IDX_W+1)'(N_REQ);
      end
      if (!o_valid && i_req[w_pos[IDX_W-1:0]]) begin
        o_valid                     = 1'b1;
        o_onehot[w_pos[IDX_W-1:0]]  = 1'b1;
        o_idx                       = w_pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dpm_req_scheduler.sv
// Power-mode sequencer (SLEEP/WAKE/ACTIVE/IDLE) with round-robin datapath grant.
// Optional saturating SLEEP->WAKE counter on wake_cnt when DPM_WAKE_CNT_EN is defined.
module dpm_req_scheduler
  import dpm_pkg::*;
#(
  parameter int N_REQ         = DPM_N_REQ_DEF,
  parameter int WAKE_LAT      = DPM_WAKE_LAT_DEF,
  parameter int IDLE_TIMEOUT  = DPM_IDLE_TIMEOUT_DEF,
  parameter int SLEEP_TIMEOUT = DPM_SLEEP_TIMEOUT_DEF,
  parameter int CNT_W         = DPM_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       grant,
  output logic [DPM_STATE_W-1:0] pwr_state,
  output logic                   clk_en,
  output logic                   pwr_en
`ifdef DPM_WAKE_CNT_EN
  ,
  output logic [DPM_WAKE_CNT_W-1:0] wake_cnt
`endif
);

  localparam int IDX_W = $clog2(N_REQ);

  pwr_state_t       r_state,   w_state_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic [N_REQ-1:0] r_grant,   w_grant_nxt;
  logic [IDX_W-1:0] r_gnt_idx, w_gnt_idx_nxt;
  logic [IDX_W-1:0] r_ptr,     w_ptr_nxt;

  logic [N_REQ-1:0] w_arb_onehot;
  logic             w_arb_valid;
  logic [IDX_W-1:0] w_arb_idx;
  logic             w_req_any;
  logic             w_busy;
  logic [CNT_W-1:0] w_cnt_inc;

  dpm_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_arb_onehot),
    .o_valid  (w_arb_valid),
    .o_idx    (w_arb_idx)
  );

  assign w_req_any = |req;
  assign w_busy    = w_req_any || (|r_grant);
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_SLEEP;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_gnt_idx <= '0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_grant   <= w_grant_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  // Grant/done handshake: grant[i] stays high until a cycle where done[i] is seen
  // while grant[i]=1; grant drops the next cycle and other done bits are ignored.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_grant_nxt   = r_grant;
    w_gnt_idx_nxt = r_gnt_idx;
    w_ptr_nxt     = r_ptr;
    case (r_state)
      ST_SLEEP: begin
        if (w_req_any) begin
          w_state_nxt = ST_WAKE;
          w_cnt_nxt   = CNT_W'(WAKE_LAT);
        end
      end
      ST_WAKE: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_ACTIVE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (|r_grant) begin
          if (|(done & r_grant)) begin
            w_grant_nxt = '0;
            w_ptr_nxt   = (r_gnt_idx == IDX_W'(N_REQ-1)) ? '0 : r_gnt_idx + IDX_W'(1);
          end
        end else if (w_arb_valid) begin
          w_grant_nxt   = w_arb_onehot;
          w_gnt_idx_nxt = w_arb_idx;
        end
        // Grant is always zero when the idle timeout can fire.
        if (w_busy) begin
          w_cnt_nxt = '0;
        end else if (r_cnt >= CNT_W'(IDLE_TIMEOUT-1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_IDLE: begin
        if (w_req_any) begin
          w_state_nxt = ST_ACTIVE;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= CNT_W'(SLEEP_TIMEOUT-1)) begin
          w_state_nxt = ST_SLEEP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_SLEEP;
        w_cnt_nxt   = '0;
        w_grant_nxt = '0;
      end
    endcase
  end

  assign grant     = r_grant;
  assign pwr_state = r_state;
  assign clk_en    = dpm_clk_en(r_state);
  assign pwr_en    = dpm_pwr_en(r_state);

`ifdef DPM_WAKE_CNT_EN
  logic [DPM_WAKE_CNT_W-1:0] r_wake_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wake_cnt <= '0;
    end else if ((r_state == ST_SLEEP) && (w_state_nxt == ST_WAKE) &&
                 (r_wake_cnt != {DPM_WAKE_CNT_W{1'b1}})) begin
      r_wake_cnt <= r_wake_cnt + DPM_WAKE_CNT_W'(1);
    end
  end

  assign wake_cnt = r_wake_cnt;
`endif

endmodule
